bridge_arbiter: RTL
===================

Name: bridge_arbiter

Overview:
Shares the single core-chain bus between two host bridges, for example the UART bridge_rx and a second host interface. Each requester presents single-cycle requests in the format bridge_rx emits (addr, data, rw, valid pulse, no backpressure). The block holds each requester's request, grants round-robin, and issues one transaction at a time onto the core chain. It waits for the chain's returned beat, with a timeout, and routes the response back to the owning requester.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data width.
TIMEOUT, 255, cycles to wait for the bus return before declaring an error. Must be >= 2 and greater than the worst-case core-chain latency.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req0_addr_i  in  ADDR_W  requester 0 address
req0_data_i  in  DATA_W  requester 0 write data
req0_rw_i  in  1  requester 0 direction, 1=write, 0=read
req0_valid_i  in  1  requester 0 single-cycle request strobe
req1_addr_i / req1_data_i / req1_rw_i / req1_valid_i  in  as req0  requester 1 request
rsp0_data_o  out  DATA_W  response data to requester 0
rsp0_rw_o  out  1  response direction (echo of request)
rsp0_err_o  out  1  response timed out
rsp0_valid_o  out  1  response strobe to requester 0
rsp1_data_o / rsp1_rw_o / rsp1_err_o / rsp1_valid_o  out  as rsp0  response to requester 1
bus_addr_o  out  ADDR_W  core-chain address
bus_data_o  out  DATA_W  core-chain write data
bus_rw_o  out  1  core-chain direction
bus_valid_o  out  1  core-chain request strobe
bus_data_i  in  DATA_W  core-chain returned data
bus_rw_i  in  1  core-chain returned direction (unused except for debug)
bus_valid_i  in  1  core-chain return strobe
busy_o  out  1  transaction in flight
overflow_o  out  2  sticky per-requester drop flag

Behaviour:
- Reset (async, immediate):
  - All outputs 0; pending slots empty; state IDLE; timer 0.
  - last_grant=1, so requester 0 wins the first tie.
- Pending slot per requester, one entry:
  - Captures addr/data/rw on valid_i when the slot is empty, or when it is being granted in the same cycle.
  - If the slot is full and not granted, the new request is dropped and overflow_o[n] is set. overflow_o stays set until reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any slot is full, grant it. When both are full, grant the requester that is not last_grant.
  - Latch the slot into the transaction register, clear the slot, update last_grant, go to ISSUE.
- ISSUE:
  - bus_valid_o=1 for exactly one cycle, with bus_addr/data/rw taken from the transaction register.
  - Timer cleared; go to WAIT.
  - bus_addr/data/rw hold their values until the next ISSUE.
- WAIT:
  - On bus_valid_i: latch bus_data_i for reads, or keep the written data for writes; err=0; go to RESP.
  - Otherwise, if timer==TIMEOUT-1: data=0, err=1, go to RESP.
  - Otherwise timer++.
  - If bus_valid_i and timeout occur in the same cycle, bus_valid_i wins (err=0).
- RESP:
  - The granted requester's rsp*_valid_o=1 for one cycle, with data, rw and err. The other requester's rsp outputs stay 0.
  - Go to IDLE.
- bus_valid_i outside WAIT is ignored.
- busy_o = (state != IDLE).
- Latency, with the block idle:
  - req valid at cycle N → bus_valid_o at N+2.
  - bus_valid_i at cycle M → rsp valid at M+1.
  - Back-to-back service: the next IDLE grant occurs in the cycle after RESP.
- Simultaneous req0/req1 strobes are both captured; no request is lost unless its slot overflows.
- Reset mid-transaction aborts with no response; in-flight chain beats arriving after reset are ignored.

Decomposition:
- Package bridge_arbiter_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - packed struct req_t {addr, data, rw};
  - localparam TIMER_W = $clog2(TIMEOUT+1).
- Sub-module bridge_arbiter_slot: one-entry pending holder with overflow flag, instantiated twice. Ports: clk, rst, req_t in/valid, take_i, full_o, req_o, overflow_o.

Test Plan:
1. Write req0 addr 16'h1234 data 16'h5678 at cycle N; bench echoes bus_valid_i 3 cycles after bus_valid_o.
   → bus_valid_o at N+2 with 1234/5678/rw=1.
   → rsp0_valid_o one cycle later: data=5678, rw=1, err=0.
   → rsp1_valid_o never asserted.
2. Same-cycle reads req0 16'hBABE and req1 16'hF00D after reset; bus returns 16'h0001 / 16'h0002.
   → issue order BABE then F00D; rsp0 data 0001, rsp1 data 0002.
   → repeat the pair: order BABE then F00D again, since last_grant=1.
3. TIMEOUT=16; read req0 16'h0000; bus_valid_i never asserted.
   → rsp0_valid_o with err=1, data=0 exactly 17 cycles after bus_valid_o; busy_o low the cycle after.
4. Bus silent, TIMEOUT=255; req0 strobed three times on cycles 0, 5, 6.
   → first issued; second held; third dropped; overflow_o=2'b01.
   → release bus: two rsp0 responses only.
5. Assert rst during WAIT.
   → all outputs 0 in the same cycle; no rsp strobe; busy_o=0.
   → a fresh request after rst deasserts completes normally.
6. TIMEOUT=16; bus_valid_i with data 16'hCAFE arrives on the timeout cycle.
   → rsp data CAFE, err=0.

Source files
------------

// File: rtl/bridge_arbiter_pkg.sv
// Shared types and constants for the two-requester core-chain bus arbiter.
// The default request layout matches the bridge_rx output format.
package bridge_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;
  localparam int TIMER_W     = $clog2(DEF_TIMEOUT + 1);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic                  rw;
  } req_t;

  // Timer width for a non-default TIMEOUT.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bridge_arbiter_slot.sv
// One-entry pending-request holder with a sticky overflow flag.
// A request arriving while the slot is full and not being taken is dropped.
module bridge_arbiter_slot
  import bridge_arbiter_pkg::*;
#(
  parameter type slot_t = bridge_arbiter_pkg::req_t
) (
  input  logic  clk,
  input  logic  rst,
  input  slot_t req_i,
  input  logic  valid_i,
  input  logic  take_i,
  output logic  full_o,
  output slot_t req_o,
  output logic  overflow_o
);

  logic  full_q, full_d;
  slot_t req_q, req_d;
  logic  ovf_q, ovf_d;
  logic  accept;

  always_comb begin
    accept = valid_i && (!full_q || take_i);
    full_d = full_q;
    req_d  = req_q;
    ovf_d  = ovf_q;
    if (accept) begin
      full_d = 1'b1;
      req_d  = req_i;
    end else if (take_i) begin
      full_d = 1'b0;
    end
    if (valid_i && full_q && !take_i) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      req_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
      ovf_q  <= ovf_d;
    end
  end

  assign full_o     = full_q;
  assign req_o      = req_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing the core-chain bus between two host bridges:
// one transaction in flight, response timeout, response routed to its owner.
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_rw_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_rw_i,
  input  logic              req1_valid_i,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_rw_o,
  output logic              rsp0_err_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_rw_o,
  output logic              rsp1_err_o,
  output logic              rsp1_valid_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_rw_o,
  output logic              bus_valid_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_rw_i,
  input  logic              bus_valid_i,
  output logic              busy_o,
  output logic [1:0]        overflow_o
);

  localparam int TMR_W = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
  } txn_t;

  txn_t       slot_in  [2];
  txn_t       slot_req [2];
  logic [1:0] slot_valid;
  logic [1:0] full;
  logic [1:0] take;
  logic       grant;
  logic       grant_ok;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  txn_t              bus_q, bus_d;
  logic              bus_valid_q, bus_valid_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              debug_rw_unused;

  assign slot_in[0] = {req0_addr_i, req0_data_i, req0_rw_i};
  assign slot_in[1] = {req1_addr_i, req1_data_i, req1_rw_i};
  assign slot_valid = {req1_valid_i, req0_valid_i};

  // With both slots full the requester that did not win last time goes next.
  assign grant    = (full[0] && full[1]) ? ~last_q : full[1];
  assign grant_ok = (state_q == IDLE) && (|full);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign take[gi] = grant_ok && (grant == 1'(gi));

      bridge_arbiter_slot #(.slot_t(txn_t)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .req_i      (slot_in[gi]),
        .valid_i    (slot_valid[gi]),
        .take_i     (take[gi]),
        .full_o     (full[gi]),
        .req_o      (slot_req[gi]),
        .overflow_o (overflow_o[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    bus_d       = bus_q;
    bus_valid_d = 1'b0;
    timer_d     = timer_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          bus_d       = slot_req[grant];
          bus_valid_d = 1'b1;
          owner_d     = grant;
          last_d      = grant;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A return beat on the timeout cycle still counts as a good response.
        if (bus_valid_i) begin
          rsp_data_d  = bus_q.rw ? bus_q.data : bus_data_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      timer_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
      timer_q     <= timer_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign debug_rw_unused = bus_rw_i;

  assign bus_addr_o  = bus_q.addr;
  assign bus_data_o  = bus_q.data;
  assign bus_rw_o    = bus_q.rw;
  assign bus_valid_o = bus_valid_q;
  assign busy_o      = (state_q != IDLE);

  // Response fields read as zero on the requester that does not own the beat.
  assign rsp0_valid_o = rsp_valid_q && !owner_q;
  assign rsp0_data_o  = rsp0_valid_o ? rsp_data_q : '0;
  assign rsp0_rw_o    = rsp0_valid_o && bus_q.rw;
  assign rsp0_err_o   = rsp0_valid_o && rsp_err_q;
  assign rsp1_valid_o = rsp_valid_q && owner_q;
  assign rsp1_data_o  = rsp1_valid_o ? rsp_data_q : '0;
  assign rsp1_rw_o    = rsp1_valid_o && bus_q.rw;
  assign rsp1_err_o   = rsp1_valid_o && rsp_err_q;

endmodule
